// File: rtl/bpu_update_queue_if.sv
// Bus between the EX stage, the update queue and the predictor update port.
// The master side is the EX stage plus the predictor (it produces resolved
// branches and the stall). The slave side is the queue itself.
interface bpu_update_queue_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int h_width    = 8,
    parameter int k_width    = 12
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [ADDR_WIDTH-1:0] ex_pc;
    logic [h_width-1:0]    ex_bh_hashed;
    logic [k_width-1:0]    ex_pc_hashed;
    logic [2:0]            ex_kind;
    logic                  ex_taken_real;
    logic                  ex_taken_pdc;
    logic [1:0]            ex_taken_pdch_b;

    logic                  upd_stall;
    logic                  upd_en;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic [h_width-1:0]    upd_bh_hashed;
    logic [k_width-1:0]    upd_pc_hashed;
    logic                  upd_taken_real;
    logic [1:0]            upd_taken_pdch_b;

    modport master (
        output ex_valid, ex_pc, ex_bh_hashed, ex_pc_hashed, ex_kind,
               ex_taken_real, ex_taken_pdc, ex_taken_pdch_b, upd_stall,
        input  ex_ready, upd_en, upd_pc, upd_bh_hashed, upd_pc_hashed,
               upd_taken_real, upd_taken_pdch_b
    );

    modport slave (
        input  ex_valid, ex_pc, ex_bh_hashed, ex_pc_hashed, ex_kind,
               ex_taken_real, ex_taken_pdc, ex_taken_pdch_b, upd_stall,
        output ex_ready, upd_en, upd_pc, upd_bh_hashed, upd_pc_hashed,
               upd_taken_real, upd_taken_pdch_b
    );
endinterface

// File: rtl/bpu_update_queue.sv
// Branch predictor update queue: buffers resolved DIRECT_JUMP outcomes from
// EX and replays them one per cycle onto the predictor's update port,
// absorbing update-port stalls and keeping branch/mispredict statistics.
module bpu_update_queue #(
    parameter int ADDR_WIDTH = 30,
    parameter int h_width    = 8,
    parameter int k_width    = 12,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rstn,
    bpu_update_queue_if.slave  bus,
    output logic               mispredict,
    output logic [31:0]        branch_cnt,
    output logic [31:0]        mispred_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [2:0] KIND_DIRECT_JUMP = 3'd1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [h_width-1:0]    bh_hashed;
        logic [k_width-1:0]    pc_hashed;
        logic                  taken_real;
        logic [1:0]            taken_pdch_b;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              empty;
    logic              full;
    logic              accept;
    logic              dequeue;
    logic              accept_mispred;
    logic [31:0]       branch_count;
    logic [31:0]       mispred_count;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign head   = mem[rd_idx];

    // Occupancy flags and the accept/dequeue decisions for this cycle.
    always_comb begin
        empty          = (wr_ptr == rd_ptr);
        full           = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
        accept         = bus.ex_valid && !full && (bus.ex_kind == KIND_DIRECT_JUMP);
        dequeue        = !empty && !bus.upd_stall;
        accept_mispred = accept && (bus.ex_taken_real != bus.ex_taken_pdc);
    end

    // Drive the EX handshake and present the head entry to the predictor.
    always_comb begin
        bus.ex_ready         = !full;
        bus.upd_en           = dequeue;
        bus.upd_pc           = head.pc;
        bus.upd_bh_hashed    = head.bh_hashed;
        bus.upd_pc_hashed    = head.pc_hashed;
        bus.upd_taken_real   = head.taken_real;
        bus.upd_taken_pdch_b = head.taken_pdch_b;
    end

    // Entry storage is data only, so it is left out of the reset domain.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_idx] <= '{pc:           bus.ex_pc,
                             bh_hashed:    bus.ex_bh_hashed,
                             pc_hashed:    bus.ex_pc_hashed,
                             taken_real:   bus.ex_taken_real,
                             taken_pdch_b: bus.ex_taken_pdch_b};
        end
    end

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (dequeue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Statistics and the one-cycle mispredict pulse for the entry just taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_count  <= '0;
            mispred_count <= '0;
            mispredict    <= 1'b0;
        end else begin
            mispredict <= accept_mispred;
            if (accept) begin
                branch_count <= branch_count + 32'd1;
            end
            if (accept_mispred) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end

    assign branch_cnt  = branch_count;
    assign mispred_cnt = mispred_count;
endmodule

// File: tb/tb_bpu_update_queue.sv
// Self-checking bench for bpu_update_queue: a queue-based reference model
// tracks what the predictor update port and the statistics must show.
module tb_bpu_update_queue;
    localparam int AW    = 30;
    localparam int HW    = 8;
    localparam int KW    = 12;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] pc;
        logic [HW-1:0] bh;
        logic [KW-1:0] ph;
        logic          tr;
        logic [1:0]    pdch;
    } entry_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    entry_t        model_q[$];
    logic [AW-1:0] deq_log[$];
    logic          exp_mispredict;
    logic [31:0]   exp_branch;
    logic [31:0]   exp_mispred;
    int            preload_seq  = 0;
    int            preload_seen = 0;
    int            checks       = 0;
    int            failures     = 0;

    bpu_update_queue_if #(.ADDR_WIDTH(AW), .h_width(HW), .k_width(KW)) bus ();

    bpu_update_queue #(
        .ADDR_WIDTH(AW), .h_width(HW), .k_width(KW), .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .mispredict  (mispredict),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge.
    task automatic apply_stimulus(input logic valid, input logic [2:0] kind,
                                  input logic [AW-1:0] pc, input logic [HW-1:0] bh,
                                  input logic [KW-1:0] ph, input logic tr,
                                  input logic pdc, input logic [1:0] pdch,
                                  input logic stall);
        @(negedge clk);
        #1;
        bus.ex_valid        = valid;
        bus.ex_kind         = kind;
        bus.ex_pc           = pc;
        bus.ex_bh_hashed    = bh;
        bus.ex_pc_hashed    = ph;
        bus.ex_taken_real   = tr;
        bus.ex_taken_pdc    = pdc;
        bus.ex_taken_pdch_b = pdch;
        bus.upd_stall       = stall;
    endtask

    task automatic idle(input logic stall);
        apply_stimulus(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 2'b00, stall);
    endtask

    // Reference model: a plain FIFO of accepted entries plus counters.
    always @(posedge clk or negedge rstn) begin : model_blk
        bit     acc;
        bit     deq;
        entry_t e;
        if (!rstn) begin
            model_q.delete();
            exp_mispredict = 1'b0;
            exp_branch     = 32'd0;
            exp_mispred    = 32'd0;
        end else begin
            acc = bus.ex_valid && (model_q.size() < DEPTH) && (bus.ex_kind == 3'd1);
            deq = (model_q.size() > 0) && !bus.upd_stall;
            if (preload_seq != preload_seen) begin
                exp_branch   = 32'hFFFF_FFFF;
                preload_seen = preload_seq;
            end
            if (deq) begin
                deq_log.push_back(model_q[0].pc);
                void'(model_q.pop_front());
            end
            exp_mispredict = acc && (bus.ex_taken_real != bus.ex_taken_pdc);
            if (acc) begin
                e.pc   = bus.ex_pc;
                e.bh   = bus.ex_bh_hashed;
                e.ph   = bus.ex_pc_hashed;
                e.tr   = bus.ex_taken_real;
                e.pdch = bus.ex_taken_pdch_b;
                model_q.push_back(e);
                exp_branch = exp_branch + 32'd1;
                if (exp_mispredict) begin
                    exp_mispred = exp_mispred + 32'd1;
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin : compare_blk
        bit exp_en;
        exp_en = (model_q.size() > 0) && (bus.upd_stall !== 1'b1);
        check_output("ex_ready", 64'(bus.ex_ready), 64'(model_q.size() < DEPTH));
        check_output("upd_en", 64'(bus.upd_en), 64'(exp_en));
        check_output("mispredict", 64'(mispredict), 64'(exp_mispredict));
        check_output("branch_cnt", 64'(branch_cnt), 64'(exp_branch));
        check_output("mispred_cnt", 64'(mispred_cnt), 64'(exp_mispred));
        if (exp_en) begin
            check_output("upd_pc", 64'(bus.upd_pc), 64'(model_q[0].pc));
            check_output("upd_bh_hashed", 64'(bus.upd_bh_hashed), 64'(model_q[0].bh));
            check_output("upd_pc_hashed", 64'(bus.upd_pc_hashed), 64'(model_q[0].ph));
            check_output("upd_taken_real", 64'(bus.upd_taken_real), 64'(model_q[0].tr));
            check_output("upd_taken_pdch_b", 64'(bus.upd_taken_pdch_b), 64'(model_q[0].pdch));
        end
    end

    initial begin
        logic [2:0] other_kinds [5];
        other_kinds = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};

        rstn                = 1'b0;
        bus.ex_valid        = 1'b0;
        bus.ex_kind         = 3'd0;
        bus.ex_pc           = '0;
        bus.ex_bh_hashed    = '0;
        bus.ex_pc_hashed    = '0;
        bus.ex_taken_real   = 1'b0;
        bus.ex_taken_pdc    = 1'b0;
        bus.ex_taken_pdch_b = 2'b00;
        bus.upd_stall       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_upd_en", 64'(bus.upd_en), 64'd0);
        check_output("reset_ex_ready", 64'(bus.ex_ready), 64'd1);
        rstn = 1'b1;

        // Non-DIRECT_JUMP kinds are consumed silently.
        foreach (other_kinds[i]) begin
            apply_stimulus(1'b1, other_kinds[i], AW'(32'h40 + i), 8'hAA, 12'h555, 1'b1, 1'b0, 2'b11, 1'b0);
            check_output("filter_ex_ready", 64'(bus.ex_ready), 64'd1);
        end
        idle(1'b0);
        idle(1'b0);
        check_output("filter_upd_en", 64'(bus.upd_en), 64'd0);
        check_output("filter_branch_cnt", 64'(branch_cnt), 64'd0);
        check_output("filter_mispred_cnt", 64'(mispred_cnt), 64'd0);

        // Single mispredicted DIRECT_JUMP.
        apply_stimulus(1'b1, 3'd1, AW'(32'h0000_1000), 8'h5A, 12'h123, 1'b1, 1'b0, 2'b01, 1'b0);
        #1;
        check_output("first_accept_cycle_upd_en", 64'(bus.upd_en), 64'd0);
        idle(1'b0);
        check_output("first_upd_en", 64'(bus.upd_en), 64'd1);
        check_output("first_upd_pc", 64'(bus.upd_pc), 64'h1000);
        check_output("first_upd_bh", 64'(bus.upd_bh_hashed), 64'h5A);
        check_output("first_upd_ph", 64'(bus.upd_pc_hashed), 64'h123);
        check_output("first_upd_tr", 64'(bus.upd_taken_real), 64'd1);
        check_output("first_upd_pdch", 64'(bus.upd_taken_pdch_b), 64'd1);
        check_output("first_mispredict", 64'(mispredict), 64'd1);
        check_output("first_branch_cnt", 64'(branch_cnt), 64'd1);
        check_output("first_mispred_cnt", 64'(mispred_cnt), 64'd1);
        idle(1'b0);
        check_output("first_mispredict_drop", 64'(mispredict), 64'd0);
        check_output("first_upd_en_drop", 64'(bus.upd_en), 64'd0);

        // Fill under stall; pc 5 must wait until the port frees up.
        deq_log.delete();
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b1, 3'd1, AW'(i), 8'(i), 12'(i), 1'b0, 1'b0, 2'b10, 1'b1);
        end
        check_output("full_ex_ready", 64'(bus.ex_ready), 64'd0);
        apply_stimulus(1'b1, 3'd1, AW'(5), 8'd5, 12'd5, 1'b0, 1'b0, 2'b10, 1'b1);
        check_output("full_hold_ex_ready", 64'(bus.ex_ready), 64'd0);
        check_output("full_hold_upd_en", 64'(bus.upd_en), 64'd0);
        apply_stimulus(1'b1, 3'd1, AW'(5), 8'd5, 12'd5, 1'b0, 1'b0, 2'b10, 1'b0);
        apply_stimulus(1'b1, 3'd1, AW'(5), 8'd5, 12'd5, 1'b0, 1'b0, 2'b10, 1'b0);
        repeat (8) idle(1'b0);
        check_output("stall_replay_count", 64'(deq_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < deq_log.size()) begin
                check_output("stall_replay_order", 64'(deq_log[i]), 64'(i + 1));
            end
        end

        // Steady one-in/one-out stream; occupancy stays at one entry.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 3'd1, AW'(32'h100 + i), 8'(i), 12'(3 * i), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
            if (i > 0) begin
                check_output("stream_upd_en", 64'(bus.upd_en), 64'd1);
                check_output("stream_upd_pc", 64'(bus.upd_pc), 64'(32'h100 + i - 1));
                check_output("stream_occupancy", 64'(model_q.size()), 64'd1);
            end
        end
        idle(1'b0);
        idle(1'b0);

        // Asynchronous reset while entries are queued behind a stall.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 3'd1, AW'(32'h200 + i), 8'h11, 12'h22, 1'b1, 1'b0, 2'b00, 1'b1);
        end
        idle(1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_output("async_reset_upd_en", 64'(bus.upd_en), 64'd0);
        check_output("async_reset_ex_ready", 64'(bus.ex_ready), 64'd1);
        check_output("async_reset_mispredict", 64'(mispredict), 64'd0);
        check_output("async_reset_branch_cnt", 64'(branch_cnt), 64'd0);
        check_output("async_reset_mispred_cnt", 64'(mispred_cnt), 64'd0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            check_output("post_reset_upd_en", 64'(bus.upd_en), 64'd0);
        end

        // Branch counter wrap from all-ones to zero.
        apply_stimulus(1'b1, 3'd1, AW'(32'h300), 8'h33, 12'h44, 1'b0, 1'b0, 2'b01, 1'b0);
        preload_seq = preload_seq + 1;
        force dut.branch_count = 32'hFFFF_FFFF;
        #1;
        release dut.branch_count;
        idle(1'b0);
        check_output("wrap_branch_cnt", 64'(branch_cnt), 64'd0);
        idle(1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [2:0] kind;
            kind = ($urandom_range(0, 9) < 6) ? 3'd1 : other_kinds[$urandom_range(0, 4)];
            apply_stimulus(1'($urandom_range(0, 3) != 0), kind, AW'($urandom), 8'($urandom),
                           12'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
        end
        repeat (8) idle(1'b0);
        check_output("drain_upd_en", 64'(bus.upd_en), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bpu_update_queue.md
Name: bpu_update_queue

Overview:
- Training-side counterpart of the branch direction predictor: collects resolved conditional-branch outcomes from EX and replays them, one per cycle, onto the predictor's update port (pc_ex, pc_ex_bh_hashed, pc_ex_hashed, taken_real, taken_pdch_ex_b, update_en).
- Decouples EX retirement from predictor write timing.
- Absorbs update-port stalls (predictor table port busy).
- Maintains branch and mispredict statistics.

Parameters:
- ADDR_WIDTH, 30, width of the word-aligned PC.
- h_width, 8, width of the PC/branch-history hashed index.
- k_width, 12, width of the plain PC hash.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents a resolved control-flow instruction
- ex_ready  out  1  queue can accept this cycle
- ex_pc  in  ADDR_WIDTH  PC of the resolved instruction
- ex_bh_hashed  in  h_width  PC/history hash captured at predict time
- ex_pc_hashed  in  k_width  PC hash captured at predict time
- ex_kind  in  3  branch kind: 0 NOT_JUMP, 1 DIRECT_JUMP, 4 RET, 5 INDIRECT_JUMP, 6 CALL, 7 JUMP
- ex_taken_real  in  1  actual direction
- ex_taken_pdc  in  1  direction predicted at fetch
- ex_taken_pdch_b  in  2  2-bit counter value read at predict time
- upd_stall  in  1  predictor update port unavailable this cycle
- upd_en  out  1  update strobe to the predictor
- upd_pc  out  ADDR_WIDTH  head-entry PC
- upd_bh_hashed  out  h_width  head-entry hashed index
- upd_pc_hashed  out  k_width  head-entry PC hash
- upd_taken_real  out  1  head-entry actual direction
- upd_taken_pdch_b  out  2  head-entry counter snapshot
- mispredict  out  1  registered one-cycle pulse: the previously accepted entry was mispredicted
- branch_cnt  out  32  accepted DIRECT_JUMP count
- mispred_cnt  out  32  accepted mispredict count

Behaviour:
- Reset (rstn low, asynchronous): read and write pointers 0, queue empty, upd_en 0, mispredict 0, branch_cnt 0, mispred_cnt 0. Entry storage need not be reset.
- Reset mid-operation discards all queued entries; no update is emitted for them.
- Pointers are log2(DEPTH)+1 bits wide.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the MSBs differ.
  - Wrap-around is natural modulo 2*DEPTH.
- ex_ready = !full. It does not depend on ex_valid, ex_kind or same-cycle dequeue; there is no full-queue bypass.
- Filter: only ex_kind == 1 (DIRECT_JUMP) is a candidate. Any other kind with ex_valid is consumed silently: no enqueue, no counter change, no mispredict.
- Accept = ex_valid && ex_ready && ex_kind == 1.
  - On accept, write {pc, bh_hashed, pc_hashed, taken_real, taken_pdch_b} at the write pointer on the clk edge.
  - Increment branch_cnt on the same edge.
- A mispredict is an accepted entry with ex_taken_real != ex_taken_pdc.
  - The edge that accepts it increments mispred_cnt and sets mispredict = 1 for exactly the following cycle.
  - Otherwise mispredict = 0.
- Counters wrap from 0xFFFFFFFF to 0.
- upd_en = !empty && !upd_stall (combinational from state and upd_stall). upd_* data are driven combinationally from the head entry.
- Dequeue on any clk edge where upd_en = 1.
- Latency: an entry accepted at edge N is presented with upd_en at the earliest in the cycle after edge N. There is no empty-queue bypass.
- Under upd_stall, the head entry and upd_* hold stable; upd_en stays 0.
- Simultaneous accept and dequeue in a non-full, non-empty state: both pointers advance and the occupancy is unchanged.
- Simultaneous accept and dequeue when empty cannot occur.
- Ordering is strict FIFO; each accepted entry produces exactly one upd_en cycle.
- When empty, upd_* values are don't-care; the bench checks them only while upd_en = 1.

Test Plan:
- Reset, then accept one entry (pc 0x0000_1000, bh 0x5A, taken_real 1, taken_pdc 0, pdch 2'b01):
  - upd_en is 0 in the accepting cycle.
  - The next cycle has upd_en = 1 with the same fields.
  - mispredict pulses for one cycle; branch_cnt = 1; mispred_cnt = 1.
- Present kinds 0, 4, 5, 6, 7 with ex_valid each cycle: queue stays empty, upd_en never rises, counters stay 0, ex_ready stays 1.
- Hold upd_stall = 1 and offer 5 consecutive DIRECT_JUMPs with pc 1..5:
  - The first 4 are accepted.
  - ex_ready drops after the 4th; pc 5 stalls until upd_stall releases.
  - After release, upd_en replays pc 1, 2, 3, 4, then 5, in order.
- Steady stream: accept one DIRECT_JUMP and dequeue one entry every cycle for 20 cycles with DEPTH = 4:
  - Occupancy stays at 1.
  - Pointers wrap at least twice.
  - Every update emerges exactly one cycle after its accept.
- Assert rstn low while 3 entries are queued and upd_stall = 1:
  - All outputs return to reset values asynchronously.
  - After release, upd_en stays 0 until a new accept.
- Preload branch_cnt to 0xFFFFFFFF (via a sequence or force), then accept one entry: branch_cnt = 0.
